spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- Memory-mapped SPI responder (mode 0, MSB first). An external SPI master drives SCK, CS_n and MOSI; this block returns bytes on MISO.
- Gives the uP a serial programming/debug port: the far-end counterpart of the storage-chip SPI controller.
- Sits on the memory map with a 2-bit register select and is serviced by software polling or by an RX interrupt.

Parameters:
- SYNC_STAGES, 2, number of flops in each pin synchronizer (minimum 2).
- UNDERRUN_BYTE, 8'h00, byte shifted out when no TX byte is pending at a byte boundary.

Ports:
- i_clk  in  1  system clock; must be at least 8x SCK.
- i_rst  in  1  synchronous active-high reset.
- i_memAddr  in  2  register select: 00 STATUS, 01 TX, 10 RX, 11 none.
- i_memDataIn  in  16  write data.
- i_memWrEn  in  1  write strobe.
- i_memRdEn  in  1  read strobe; used only for side effects.
- o_memDataOut  out  16  combinational read data for i_memAddr.
- i_spiSCK  in  1  external serial clock (asynchronous).
- i_spiCSn  in  1  external chip select, active low (asynchronous).
- i_spiMOSI  in  1  external serial data in (asynchronous).
- o_spiMISO  out  1  serial data out, equal to txShift[7].
- o_spiMisoEn  out  1  MISO drive enable; 1 while the synchronized CS_n is low.
- o_rxIntr  out  1  level interrupt, equal to rxValid.

Behaviour:
- **Reset.** All registers clear on i_clk when i_rst=1. Exceptions: the CS_n synchronizer resets to 1 and the SCK synchronizer resets to 0. Resulting outputs: o_spiMISO=0, o_spiMisoEn=0, o_rxIntr=0, all flags 0, bitCnt=0.
- **Reset mid-frame.** A reset during a frame drops the partial byte. No flags are set.
- **Synchronization.** SCK, CS_n and MOSI each pass through SYNC_STAGES flops. One extra flop on SCK and CS_n provides edge detect. A pin change is acted on SYNC_STAGES+1 clocks later.
- **Frame start.** On the CS_n falling edge:
  - bitCnt=0.
  - If txPend=1: txShift loads TX and txPend clears.
  - If txPend=0: txShift loads UNDERRUN_BYTE and the underrun flag sets.
- **SCK rising edge** (only while CS_n is low):
  - rxShift becomes {rxShift[6:0], MOSI}; bitCnt increments.
  - On the 8th rising edge (bitCnt 7 to 0), the byte completes: RX takes {rxShift[6:0], MOSI} and rxValid is set. Reload is also armed.
  - If rxValid was already 1 and no clearing read occurs in that same cycle: the overrun flag sets, the new byte is dropped and RX keeps the old value.
- **SCK falling edge** (only while CS_n is low):
  - If reload is armed: txShift loads TX (txPend clears) or UNDERRUN_BYTE (underrun sets), then reload disarms.
  - Otherwise: txShift becomes {txShift[6:0], 0}.
- **Frame end.** On the CS_n rising edge:
  - If bitCnt != 0, the frame-error flag sets and the partial byte is discarded.
  - bitCnt=0; reload disarms.
  - o_spiMisoEn drops in the same cycle.
- **SCK edges while CS_n is high** are ignored.
- **Register map**, read side:
  - STATUS reads {rxValid, txPend, overrun, underrun, frameErr, csActive, 10'b0}.
  - TX reads the pending TX byte, zero-extended.
  - RX reads the RX byte, zero-extended.
  - Address 11 reads 0.
- **Register map**, write side:
  - STATUS: writing 1 to bit 13, 12 or 11 clears overrun, underrun or frameErr respectively. All other bits are read-only.
  - TX: the write loads TX[7:0] and sets txPend. A write while txPend=1 overwrites the pending byte without setting any flag.
  - A TX write in the same cycle as a TX load into txShift: the shift register takes the old TX value, and TX then holds the new value with txPend=1.
- **RX read.** i_memRdEn with address 10 clears rxValid on the next edge. If a clearing read and a byte completion happen in the same cycle, the completion wins: RX updates, rxValid stays 1, no overrun.
- **Flag clear vs set.** A sticky-flag set and a write-1-clear of that flag in the same cycle: the set wins.

Test Plan:
- **Basic exchange.** Write TX=0xA5, then the master clocks one byte of 0x3C with SCK = i_clk/16. Required: MISO carries 1,0,1,0,0,1,0,1; RX reads 0x003C; STATUS reads 0x8000 after CS_n rises; o_rxIntr=1; a read of address 10 with i_memRdEn clears o_rxIntr.
- **Two bytes, one TX pending.** TX=0x81 is written before the frame; the master sends 0x11 then 0x22 with no software service in between. Required: second MISO byte is 0x00; underrun is set; RX=0x11; overrun is set (0x22 dropped); STATUS reads 0xB000 after CS_n rises (rxValid, txPend=0, overrun, underrun).
- **Partial frame.** CS_n rises after 5 SCK pulses. Required: frameErr=1; rxValid=0; writing 0x0800 to STATUS clears frameErr, after which STATUS reads 0x0000.
- **Read-clear vs completion.** rxValid=1 with RX=0x55. A read of address 10 with i_memRdEn lands on the same cycle as the 8th rising edge of byte 0x66. Required: RX=0x66, rxValid=1, overrun=0.
- **Reset mid-frame.** Assert i_rst after 3 bits, with CS_n still low and TX=0x7E pending. Required: all STATUS bits 0, o_spiMisoEn=0 and o_spiMISO=0, TX reads 0x0000. Release reset while CS_n is still low: no frame starts until CS_n goes high and then low again.
- **Noise while deselected.** 20 SCK toggles with CS_n high. Required: bitCnt stays 0, no flags set, MISO not driven.

Source files
------------

// File: rtl/spi_target.sv
// spi_target: memory-mapped SPI responder, mode 0, MSB first.
// The external master owns SCK/CS_n/MOSI; all three pins are synchronized
// into i_clk and every serial event is handled as a single-cycle strobe.
// Software sees a STATUS/TX/RX register triple and an RX level interrupt.
module spi_target #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_memAddr,
    input  logic [15:0] i_memDataIn,
    input  logic        i_memWrEn,
    input  logic        i_memRdEn,
    output logic [15:0] o_memDataOut,
    input  logic        i_spiSCK,
    input  logic        i_spiCSn,
    input  logic        i_spiMOSI,
    output logic        o_spiMISO,
    output logic        o_spiMisoEn,
    output logic        o_rxIntr
);

    localparam logic [1:0] ADDR_STATUS = 2'b00;
    localparam logic [1:0] ADDR_TX     = 2'b01;
    localparam logic [1:0] ADDR_RX     = 2'b10;

    // Frame tracking: WAIT holds off after reset until CS_n has been seen
    // high through the synchronizer, so a reset released mid-frame never
    // starts a frame on the tail of the old one.
    typedef enum logic [1:0] {
        ST_WAIT,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   sck_d;

    logic sck, cs_n, mosi, sync_ok;
    logic sck_rise, sck_fall;
    logic cs_fall, cs_rise, frame_on;

    logic [7:0] tx_data, tx_shift, rx_shift, rx_data;
    logic       tx_pend, rx_valid, reload;
    logic       overrun, underrun, frame_err;
    logic [2:0] bit_cnt;

    logic wr_tx, wr_status, rd_rx;
    logic rise_on, fall_on, byte_done, tx_load;
    logic overrun_set, underrun_set, frame_err_set;

    logic unused_data;
    assign unused_data = ^{i_memDataIn[15:14], i_memDataIn[10:8]};

    // Pin synchronizers; vld_pipe marks which stages hold real pin samples
    // rather than reset values. CS_n resets high (deselected).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            vld_pipe  <= '0;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spiSCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spiCSn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spiMOSI};
            vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck;
        end
    end

    assign sck      = sck_sync[SYNC_STAGES-1];
    assign cs_n     = cs_sync[SYNC_STAGES-1];
    assign mosi     = mosi_sync[SYNC_STAGES-1];
    assign sync_ok  = vld_pipe[SYNC_STAGES-1];
    assign sck_rise = sck & ~sck_d;
    assign sck_fall = ~sck & sck_d;

    // Frame state register; the state doubles as the CS_n edge-detect flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_WAIT;
        else       state <= state_nxt;
    end

    // Frame next-state and CS_n edge strobes.
    always_comb begin
        state_nxt = state;
        cs_fall   = 1'b0;
        cs_rise   = 1'b0;
        frame_on  = 1'b0;
        case (state)
            ST_WAIT: begin
                if (sync_ok && cs_n) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (!cs_n) begin
                    cs_fall   = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_n) begin
                    cs_rise   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    frame_on  = 1'b1;
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    assign wr_tx     = i_memWrEn && (i_memAddr == ADDR_TX);
    assign wr_status = i_memWrEn && (i_memAddr == ADDR_STATUS);
    assign rd_rx     = i_memRdEn && (i_memAddr == ADDR_RX);

    assign rise_on   = frame_on & sck_rise;
    assign fall_on   = frame_on & sck_fall;
    assign byte_done = rise_on && (bit_cnt == 3'd7);
    // TX byte is pulled into the shifter at frame start and on the falling
    // edge that follows each completed byte.
    assign tx_load   = cs_fall | (fall_on & reload);

    assign overrun_set   = byte_done & rx_valid & ~rd_rx;
    assign underrun_set  = tx_load & ~tx_pend;
    assign frame_err_set = cs_rise && (bit_cnt != 3'd0);

    // TX holding register and shifter; a same-cycle TX write leaves the old
    // byte going into the shifter and the new one pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_data  <= '0;
            tx_pend  <= 1'b0;
            tx_shift <= '0;
        end else begin
            if (wr_tx)        tx_data <= i_memDataIn[7:0];
            if (wr_tx)        tx_pend <= 1'b1;
            else if (tx_load) tx_pend <= 1'b0;
            if (tx_load)      tx_shift <= tx_pend ? tx_data : UNDERRUN_BYTE;
            else if (fall_on) tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    // Bit counter and reload arm; frame edges restart the byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt <= '0;
            reload  <= 1'b0;
        end else begin
            if (cs_fall || cs_rise) bit_cnt <= '0;
            else if (rise_on)       bit_cnt <= bit_cnt + 3'd1;
            if (cs_rise)            reload <= 1'b0;
            else if (byte_done)     reload <= 1'b1;
            else if (tx_load)       reload <= 1'b0;
        end
    end

    // RX shifter and holding register; completion beats a same-cycle clear,
    // and a byte landing on an unread RX is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (rise_on) rx_shift <= {rx_shift[6:0], mosi};
            if (byte_done && !overrun_set) begin
                rx_data  <= {rx_shift[6:0], mosi};
                rx_valid <= 1'b1;
            end else if (rd_rx && !byte_done) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Sticky error flags, write-1-to-clear; a set in the same cycle wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= overrun_set   | (overrun   & ~(wr_status & i_memDataIn[13]));
            underrun  <= underrun_set  | (underrun  & ~(wr_status & i_memDataIn[12]));
            frame_err <= frame_err_set | (frame_err & ~(wr_status & i_memDataIn[11]));
        end
    end

    // Register read mux.
    always_comb begin
        o_memDataOut = '0;
        case (i_memAddr)
            ADDR_STATUS: o_memDataOut = {rx_valid, tx_pend, overrun, underrun,
                                         frame_err, frame_on, 10'b0};
            ADDR_TX:     o_memDataOut = {8'h00, tx_data};
            ADDR_RX:     o_memDataOut = {8'h00, rx_data};
            default:     o_memDataOut = '0;
        endcase
    end

    assign o_spiMISO   = tx_shift[7];
    assign o_spiMisoEn = frame_on;
    assign o_rxIntr    = rx_valid;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed scenarios for spi_target with SCK = clk/16.
module tb_spi_target;

    localparam int SYNC = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic [15:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] dout;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_en;
    logic        rx_intr;

    int vec_cnt = 0;
    int err_cnt = 0;

    spi_target #(.SYNC_STAGES(SYNC), .UNDERRUN_BYTE(8'h00)) dut (
        .i_clk(clk), .i_rst(rst), .i_memAddr(addr), .i_memDataIn(din),
        .i_memWrEn(wr_en), .i_memRdEn(rd_en), .o_memDataOut(dout),
        .i_spiSCK(sck), .i_spiCSn(cs_n), .i_spiMOSI(mosi),
        .o_spiMISO(miso), .o_spiMisoEn(miso_en), .o_rxIntr(rx_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; addr = 2'b11; din = '0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(8);
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; din = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        addr = a;
        #1 d = dout;
    endtask

    task automatic rx_clear_read();
        @(negedge clk);
        addr = 2'b10; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        wait_clk(1);
    endtask

    task automatic frame_begin();
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    // end_high: SCK was left high after the last bit and falls only after
    // CS_n has gone high.
    task automatic frame_end(input bit end_high);
        @(negedge clk);
        cs_n = 1'b1;
        wait_clk(8);
        if (end_high) sck = 1'b0;
        wait_clk(8);
    endtask

    // Clock nbits of mosi_b MSB first, sampling MISO before each rising edge.
    // rd_last places an RX read strobe on the cycle the last rise is acted on.
    task automatic spi_bits(input logic [7:0] mosi_b, input int nbits,
                            input bit end_high, input bit rd_last,
                            output logic [7:0] miso_b);
        miso_b = '0;
        for (int k = 0; k < nbits; k++) begin
            mosi = mosi_b[7-k];
            wait_clk(8);
            miso_b[7-k] = miso;
            sck = 1'b1;
            if (rd_last && k == nbits - 1) begin
                wait_clk(SYNC);
                addr = 2'b10; rd_en = 1'b1;
                wait_clk(1);
                rd_en = 1'b0;
                wait_clk(8 - SYNC - 1);
            end else begin
                wait_clk(8);
            end
            if (!(end_high && k == nbits - 1)) sck = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        do_reset();
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h0000) begin err_cnt++; $display("FAIL reset_status got %h exp %h", d, 16'h0000); end
        reg_rd(2'b01, d); vec_cnt++;
        if (d !== 16'h0000) begin err_cnt++; $display("FAIL reset_tx got %h exp %h", d, 16'h0000); end
        reg_rd(2'b11, d); vec_cnt++;
        if (d !== 16'h0000) begin err_cnt++; $display("FAIL reset_addr3 got %h exp %h", d, 16'h0000); end
        vec_cnt++;
        if ({miso, miso_en, rx_intr} !== 3'b000) begin
            err_cnt++; $display("FAIL reset_pins got %b exp 000", {miso, miso_en, rx_intr});
        end
    endtask

    task automatic test_basic();
        logic [15:0] d;
        logic [7:0]  mb;
        do_reset();
        reg_wr(2'b01, 16'h00A5);
        frame_begin();
        vec_cnt++;
        if (miso_en !== 1'b1) begin err_cnt++; $display("FAIL basic_miso_en got %b exp 1", miso_en); end
        spi_bits(8'h3C, 8, 1'b1, 1'b0, mb);
        frame_end(1'b1);
        vec_cnt++;
        if (mb !== 8'hA5) begin err_cnt++; $display("FAIL basic_miso got %h exp %h", mb, 8'hA5); end
        reg_rd(2'b10, d); vec_cnt++;
        if (d !== 16'h003C) begin err_cnt++; $display("FAIL basic_rx got %h exp %h", d, 16'h003C); end
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h8000) begin err_cnt++; $display("FAIL basic_status got %h exp %h", d, 16'h8000); end
        vec_cnt++;
        if (rx_intr !== 1'b1) begin err_cnt++; $display("FAIL basic_intr got %b exp 1", rx_intr); end
        rx_clear_read();
        vec_cnt++;
        if (rx_intr !== 1'b0) begin err_cnt++; $display("FAIL basic_intr_clr got %b exp 0", rx_intr); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [7:0]  mb0, mb1;
        do_reset();
        reg_wr(2'b01, 16'h0081);
        frame_begin();
        spi_bits(8'h11, 8, 1'b0, 1'b0, mb0);
        spi_bits(8'h22, 8, 1'b1, 1'b0, mb1);
        frame_end(1'b1);
        vec_cnt++;
        if (mb0 !== 8'h81) begin err_cnt++; $display("FAIL b2b_miso0 got %h exp %h", mb0, 8'h81); end
        vec_cnt++;
        if (mb1 !== 8'h00) begin err_cnt++; $display("FAIL b2b_miso1 got %h exp %h", mb1, 8'h00); end
        reg_rd(2'b10, d); vec_cnt++;
        if (d !== 16'h0011) begin err_cnt++; $display("FAIL b2b_rx got %h exp %h", d, 16'h0011); end
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'hB000) begin err_cnt++; $display("FAIL b2b_status got %h exp %h", d, 16'hB000); end
    endtask

    task automatic test_partial();
        logic [15:0] d;
        logic [7:0]  mb;
        do_reset();
        reg_wr(2'b01, 16'h0000);
        frame_begin();
        spi_bits(8'hF0, 5, 1'b0, 1'b0, mb);
        frame_end(1'b0);
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h0800) begin err_cnt++; $display("FAIL partial_status got %h exp %h", d, 16'h0800); end
        vec_cnt++;
        if (rx_intr !== 1'b0) begin err_cnt++; $display("FAIL partial_intr got %b exp 0", rx_intr); end
        reg_wr(2'b00, 16'h0800);
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h0000) begin err_cnt++; $display("FAIL partial_clr got %h exp %h", d, 16'h0000); end
    endtask

    task automatic test_read_vs_complete();
        logic [15:0] d;
        logic [7:0]  mb;
        do_reset();
        frame_begin();
        spi_bits(8'h55, 8, 1'b1, 1'b0, mb);
        frame_end(1'b1);
        reg_rd(2'b10, d); vec_cnt++;
        if (d !== 16'h0055) begin err_cnt++; $display("FAIL rvc_rx0 got %h exp %h", d, 16'h0055); end
        frame_begin();
        spi_bits(8'h66, 8, 1'b1, 1'b1, mb);
        frame_end(1'b1);
        reg_rd(2'b10, d); vec_cnt++;
        if (d !== 16'h0066) begin err_cnt++; $display("FAIL rvc_rx1 got %h exp %h", d, 16'h0066); end
        reg_rd(2'b00, d); vec_cnt++;
        if ({d[15], d[13]} !== 2'b10) begin
            err_cnt++; $display("FAIL rvc_flags got valid=%b ovr=%b exp valid=1 ovr=0", d[15], d[13]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        logic [7:0]  mb;
        do_reset();
        reg_wr(2'b01, 16'h007E);
        frame_begin();
        spi_bits(8'hA0, 3, 1'b0, 1'b0, mb);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h0000) begin err_cnt++; $display("FAIL rmf_status got %h exp %h", d, 16'h0000); end
        vec_cnt++;
        if ({miso_en, miso} !== 2'b00) begin
            err_cnt++; $display("FAIL rmf_pins got en=%b miso=%b exp 00", miso_en, miso);
        end
        reg_rd(2'b01, d); vec_cnt++;
        if (d !== 16'h0000) begin err_cnt++; $display("FAIL rmf_tx got %h exp %h", d, 16'h0000); end
        spi_bits(8'hFF, 8, 1'b0, 1'b0, mb);
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h0000) begin err_cnt++; $display("FAIL rmf_nostart got %h exp %h", d, 16'h0000); end
        vec_cnt++;
        if (miso_en !== 1'b0) begin err_cnt++; $display("FAIL rmf_noen got %b exp 0", miso_en); end
        frame_end(1'b0);
        frame_begin();
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h1400) begin err_cnt++; $display("FAIL rmf_restart got %h exp %h", d, 16'h1400); end
        vec_cnt++;
        if (miso_en !== 1'b1) begin err_cnt++; $display("FAIL rmf_en got %b exp 1", miso_en); end
        frame_end(1'b0);
    endtask

    task automatic test_noise();
        logic [15:0] d;
        logic [7:0]  mb;
        do_reset();
        for (int t = 0; t < 20; t++) begin
            mosi = t[0];
            sck  = ~sck;
            wait_clk(4);
        end
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h0000) begin err_cnt++; $display("FAIL noise_status got %h exp %h", d, 16'h0000); end
        vec_cnt++;
        if (miso_en !== 1'b0) begin err_cnt++; $display("FAIL noise_en got %b exp 0", miso_en); end
        reg_wr(2'b01, 16'h00C3);
        frame_begin();
        spi_bits(8'h5A, 8, 1'b1, 1'b0, mb);
        frame_end(1'b1);
        vec_cnt++;
        if (mb !== 8'hC3) begin err_cnt++; $display("FAIL noise_miso got %h exp %h", mb, 8'hC3); end
        reg_rd(2'b10, d); vec_cnt++;
        if (d !== 16'h005A) begin err_cnt++; $display("FAIL noise_rx got %h exp %h", d, 16'h005A); end
        reg_rd(2'b00, d); vec_cnt++;
        if (d !== 16'h8000) begin err_cnt++; $display("FAIL noise_status2 got %h exp %h", d, 16'h8000); end
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; addr = 2'b11; din = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_partial();
        test_read_vs_complete();
        test_reset_mid_frame();
        test_noise();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
